uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from a FWFT TX FIFO and frames them
// (start, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop) on the 16x baud tick.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       sp_i,
    input  logic       brk_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_pop_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int TW = $clog2(2 * OVERSAMPLE);
    localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n, tick_last;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    data_q, data_n;
    logic [1:0]    wls_q, wls_n;
    logic          stb_q, stb_n;
    logic          pen_q, pen_n;
    logic          par_q, par_n;
    logic          tx_q, line_n;
    logic          load, tick_done;
    logic [7:0]    word_mask;
    logic          par_in;

    // Parity is resolved at load time from the incoming word and LCR, so the
    // frame carries a single precomputed bit instead of eps/sp.
    always_comb begin
        word_mask = 8'hFF >> (2'd3 - wls_i);
        par_in    = sp_i ? ~eps_i : ((^(fifo_data_i & word_mask)) ^ ~eps_i);
    end

    always_comb begin
        tick_last = BIT_LAST;
        if (state == STOP && stb_q)
            tick_last = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
        tick_done = (tick == tick_last);
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_idx_n = bit_idx;
        data_n    = data_q;
        wls_n     = wls_q;
        stb_n     = stb_q;
        pen_n     = pen_q;
        par_n     = par_q;
        load      = 1'b0;

        if (baud_pulse_i) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty_i) load = 1'b1;
                end
                START: begin
                    if (tick_done) begin
                        state_n   = DATA;
                        tick_n    = '0;
                        bit_idx_n = '0;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_done) begin
                        tick_n = '0;
                        if (bit_idx == ({1'b0, wls_q} + 3'd4))
                            state_n = pen_q ? PARITY : STOP;
                        else
                            bit_idx_n = bit_idx + 3'd1;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                PARITY: begin
                    if (tick_done) begin
                        state_n = STOP;
                        tick_n  = '0;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_done) begin
                        tick_n = '0;
                        // Reload straight into START so consecutive frames have no gap.
                        if (!fifo_empty_i) load = 1'b1;
                        else               state_n = IDLE;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (load) begin
            state_n   = START;
            tick_n    = '0;
            bit_idx_n = '0;
            data_n    = fifo_data_i;
            wls_n     = wls_i;
            stb_n     = stb_i;
            pen_n     = pen_i;
            par_n     = par_in;
        end

        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = data_n[bit_idx_n];
            PARITY:  line_n = par_n;
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_idx_n;
            data_q  <= data_n;
            wls_q   <= wls_n;
            stb_q   <= stb_n;
            pen_q   <= pen_n;
            par_q   <= par_n;
            tx_q    <= brk_i ? 1'b0 : line_n;
        end
    end

    // Reset gates the pop so a held reset never drains the FIFO.
    assign fifo_pop_o = load & ~rst;
    assign tx_o       = tx_q;
    assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: logs tx/busy after every baud pulse
// and checks framed bit periods, frame lengths and pop counts.
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, brk = 1'b0;
    logic       fifo_empty, fifo_pop, tx, busy;
    logic [7:0] fifo_data;

    logic [7:0] fifo_mem [16];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;

    int   period = 4;
    int   pop_cnt = 0;
    logic pend = 1'b0;
    logic tx_log[$];
    logic busy_log[$];
    int   n_chk = 0;
    int   n_err = 0;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .baud_pulse_i(baud_pulse),
        .wls_i(wls), .stb_i(stb), .pen_i(pen), .eps_i(eps), .sp_i(sp), .brk_i(brk),
        .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_pop_o(fifo_pop),
        .tx_o(tx), .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_data  = fifo_mem[rd_ptr];
    always @(posedge clk) if (fifo_pop) rd_ptr <= rd_ptr + 4'd1;

    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            if (div >= period - 1) begin baud_pulse = 1'b1; div = 0; end
            else begin baud_pulse = 1'b0; div++; end
        end
    end

    // One log entry per consumed baud pulse, taken half a clock after that edge.
    always @(negedge clk) begin
        if (pend) begin
            tx_log.push_back(tx);
            busy_log.push_back(busy);
        end
        pend = baud_pulse;
        if (fifo_pop) pop_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                           input logic e, input logic k);
        wls = w; stb = s; pen = p; eps = e; sp = k;
    endtask

    task automatic wait_entries(input string tag, input int n);
        int t;
        t = 0;
        while (tx_log.size() < n && t < 4000) begin
            @(posedge clk); #1; t++;
        end
        chk(tag, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic find_start(input string tag, input int from, output int s);
        int t;
        s = -1;
        t = 0;
        while (s < 0 && t < 4000) begin
            for (int k = from; k < busy_log.size(); k++)
                if (busy_log[k] && s < 0) s = k;
            if (s < 0) begin @(posedge clk); #1; t++; end
        end
        chk(tag, 32'(s >= 0), 32'd1);
        if (s < 0) s = 0;
    endtask

    task automatic check_bits(input string tag, input int s, input int nper, input logic [31:0] exp);
        logic [31:0] obs;
        int idx;
        obs = '0;
        for (int i = 0; i < nper; i++) begin
            idx = s + OS * i + OS / 2;
            if (idx < tx_log.size()) obs[i] = tx_log[idx];
        end
        chk(tag, obs, exp);
    endtask

    task automatic check_len(input string tag, input int s, input int len);
        int k;
        k = s;
        while (k < busy_log.size() && busy_log[k]) k++;
        chk(tag, 32'(k - s), 32'(len));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input int nper,
                             input logic [31:0] exp_bits, input int len);
        int s, from, base;
        base = pop_cnt;
        from = tx_log.size();
        push(b);
        find_start({tag, "_start"}, from, s);
        wait_entries({tag, "_wait"}, s + len + 1);
        check_bits({tag, "_bits"}, s, nper, exp_bits);
        check_len({tag, "_len"}, s, len);
        chk({tag, "_pops"}, 32'(pop_cnt - base), 32'd1);
        chk({tag, "_idle_tx"}, 32'(tx_log[s + len]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, from, base, ones;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("8n1_a5", 8'hA5, 10, 32'h34A, 160);
        set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        run_frame("7e1_41", 8'h41, 10, 32'h282, 160);
        set_lcr(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame("8o2_03", 8'h03, 12, 32'hE06, 192);
        set_lcr(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame("5s15_ff", 8'hFF, 8, 32'h0FE, 136);

        // Three preloaded bytes stream without gaps.
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        base = pop_cnt;
        from = tx_log.size();
        push(8'h11); push(8'h22); push(8'h33);
        find_start("b2b_start", from, s);
        wait_entries("b2b_wait", s + 481);
        check_bits("b2b_bits0", s,       10, 32'h222);
        check_bits("b2b_bits1", s + 160, 10, 32'h244);
        check_bits("b2b_bits2", s + 320, 10, 32'h266);
        check_len("b2b_len", s, 480);
        chk("b2b_pops", 32'(pop_cnt - base), 32'd3);

        // Break over 20 pulses inside DATA, then shrink wls mid-frame.
        from = tx_log.size();
        push(8'h55);
        find_start("brk_start", from, s);
        wait_entries("brk_wait_on", s + 38);
        brk = 1'b1;
        wait_entries("brk_wait_off", s + 58);
        brk = 1'b0;
        wls = 2'b00;
        wait_entries("brk_wait_end", s + 161);
        ones = 0;
        for (int k = s + 38; k < s + 58; k++) if (tx_log[k]) ones++;
        chk("brk_low", 32'(ones), 32'd0);
        check_bits("brk_bits", s, 10, 32'h2A2);
        check_len("brk_len", s, 160);

        // Reset in the middle of data bit 3; the second byte must go out cleanly.
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        base = pop_cnt;
        from = tx_log.size();
        push(8'h0F); push(8'h3C);
        find_start("rstm_start", from, s);
        wait_entries("rstm_wait", s + 68);
        rst = 1'b1;
        #1;
        chk("rstm_tx", 32'(tx), 32'd1);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_pop", 32'(fifo_pop), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("rstm_nopop", 32'(pop_cnt - base), 32'd1);
        rst = 1'b0;
        from = tx_log.size();
        find_start("rstm_restart", from, s);
        wait_entries("rstm_wait2", s + 161);
        check_bits("rstm_bits", s, 10, 32'h278);
        check_len("rstm_len", s, 160);
        chk("rstm_pops", 32'(pop_cnt - base), 32'd2);

        // Baud pulse held high: every clock is a tick.
        period = 1;
        repeat (2) @(posedge clk);
        #1;
        run_frame("cont_96", 8'h96, 10, 32'h32C, 160);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
